weight_bank_ctrl: RTL and testbench

Parametrised, double-buffered weight-staging controller between the host weight port and the systolic array. It writes incoming weight rows round-robin into `NUM_BANKS` single-port SRAM banks, holding up to two complete weight sets (ping/pong). On command it reads the oldest complete set back, one row per cycle, and streams it to the array. It replaces the fixed 8-bank, single-set weight path of the controller and adds buffering, backpressure and error reporting.

---
 rtl/weight_bank_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_weight_bank_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_bank_ctrl.sv
// -----------------------------------------------------------------------------
// weight_bank_ctrl
//
// Double-buffered weight staging between the host weight port and the systolic
// array. Host rows are written round-robin across NUM_BANKS single-port SRAM
// banks. Each bank holds two slots (ping = addr 0, pong = addr 1), so up to two
// complete weight sets can be buffered. On request the oldest complete set is
// read back one row per cycle and streamed to the array.
//
// Optional feature macro: WEIGHT_BANK_CTRL_AUTO_LOAD_EN
//   defined   : a full set at the read slot starts a stream by itself while
//               idle; load_weights flags err only when idle with nothing full.
//   undefined : streams start only on load_weights.
//
// Parameters
//   NUM_BANKS  banks, also rows per set (power of two, >= 2)
//   DATA_W     row width
//   ADDR_W     SRAM address width
//   READ_LAT   SRAM read latency, 1..3
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   wr_valid/wr_data   host row in; wr_ready accepts it
//   load_weights       pulse: stream the oldest full set
//   busy               FSM not idle
//   start_weights      pulse in the first READ cycle
//   sys_valid/sys_data/sys_row  streamed row to the array
//   weights_done       pulse in the DONE cycle
//   err                pulse on a dropped row or an illegal load
//   sram_cs/we/addr/wdata  SRAM request (one-hot bank select)
//   sram_rdata         all banks' read data, bank b at [b*DATA_W +: DATA_W]
// -----------------------------------------------------------------------------
module weight_bank_ctrl #(
  parameter int NUM_BANKS = 8,
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 10,
  parameter int READ_LAT  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_valid,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          wr_ready,
  input  logic                          load_weights,
  output logic                          busy,
  output logic                          start_weights,
  output logic                          sys_valid,
  output logic [DATA_W-1:0]             sys_data,
  output logic [$clog2(NUM_BANKS)-1:0]  sys_row,
  output logic                          weights_done,
  output logic                          err,
  output logic [NUM_BANKS-1:0]          sram_cs,
  output logic                          sram_we,
  output logic [ADDR_W-1:0]             sram_addr,
  output logic [DATA_W-1:0]             sram_wdata,
  input  logic [NUM_BANKS*DATA_W-1:0]   sram_rdata
);

  localparam int ROW_W = $clog2(NUM_BANKS);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_BANKS - 1);
  localparam logic [1:0]       LAST_DRAIN = 2'(READ_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                           r_state;
  state_t                           w_state_nxt;
  logic                             r_wr_buf;
  logic                             r_rd_buf;
  logic [ROW_W-1:0]                 r_wr_row;
  logic [ROW_W-1:0]                 r_rd_row;
  logic [1:0]                       r_full;
  logic [1:0]                       r_drain_cnt;
  // Issued-read tracking: one stage per cycle of SRAM latency.
  logic [READ_LAT-1:0]              r_pipe_vld;
  logic [READ_LAT-1:0][ROW_W-1:0]   r_pipe_row;

  logic w_wr_ready;
  logic w_wr_fire;
  logic w_set_done;
  logic w_rd_issue;
  logic w_start_req;
  logic w_load_err;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  // The SRAM port is owned by the read stream during READ; outside READ a write
  // may land in any slot whose set is not yet full.
  assign w_wr_ready = !r_full[r_wr_buf] && (r_state != S_READ);
  assign w_wr_fire  = wr_valid && w_wr_ready;
  assign w_set_done = w_wr_fire && (r_wr_row == LAST_ROW);
  assign w_rd_issue = (r_state == S_READ);

  // Loads look at the registered full flags, so a set that completes in the
  // same cycle as a load is not yet visible to it.
`ifdef WEIGHT_BANK_CTRL_AUTO_LOAD_EN
  assign w_start_req = (r_state == S_IDLE) && r_full[r_rd_buf];
  assign w_load_err  = load_weights && (r_state == S_IDLE) && (r_full == 2'b00);
`else
  assign w_start_req = load_weights && (r_state == S_IDLE) && r_full[r_rd_buf];
  assign w_load_err  = load_weights && ((r_state != S_IDLE) || !r_full[r_rd_buf]);
`endif

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default at the top so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start_req) w_state_nxt = S_READ;
      S_READ:  if (r_rd_row == LAST_ROW) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_drain_cnt == LAST_DRAIN) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, counters and buffer bookkeeping
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order in the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wr_buf    <= 1'b0;
      r_rd_buf    <= 1'b0;
      r_wr_row    <= '0;
      r_rd_row    <= '0;
      r_full      <= 2'b00;
      r_drain_cnt <= 2'd0;
      r_pipe_vld  <= '0;
      r_pipe_row  <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_wr_fire) begin
        r_wr_row <= r_wr_row + 1'b1;
        if (w_set_done) r_wr_buf <= ~r_wr_buf;
      end

      // rd_row wraps back to 0 after the last row, ready for the next stream.
      if (w_rd_issue) r_rd_row <= r_rd_row + 1'b1;

      r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + 2'd1 : 2'd0;

      // A completing write can never target the slot being released in DONE
      // (that slot is still full), so the set and clear touch different bits.
      if (r_state == S_DONE) begin
        r_full[r_rd_buf] <= 1'b0;
        r_rd_buf         <= ~r_rd_buf;
      end
      if (w_set_done) r_full[r_wr_buf] <= 1'b1;

      r_pipe_vld[0] <= w_rd_issue;
      r_pipe_row[0] <= r_rd_row;
      for (int i = 1; i < READ_LAT; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_row[i] <= r_pipe_row[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // SRAM request: a write and a read never coincide because wr_ready is low
  // for the whole READ state.
  // ---------------------------------------------------------------------------
  always_comb begin
    sram_cs    = '0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (w_wr_fire) begin
      sram_cs    = NUM_BANKS'(1) << r_wr_row;
      sram_we    = 1'b1;
      sram_addr  = ADDR_W'(r_wr_buf);
      sram_wdata = wr_data;
    end else if (w_rd_issue) begin
      sram_cs   = NUM_BANKS'(1) << r_rd_row;
      sram_addr = ADDR_W'(r_rd_buf);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign wr_ready      = w_wr_ready;
  assign busy          = (r_state != S_IDLE);
  // rd_row is 0 inside READ only on the first cycle of a stream.
  assign start_weights = (r_state == S_READ) && (r_rd_row == '0);
  assign weights_done  = (r_state == S_DONE);
  assign err           = w_load_err || (wr_valid && !w_wr_ready);

  assign sys_valid = r_pipe_vld[READ_LAT-1];
  assign sys_row   = sys_valid ? r_pipe_row[READ_LAT-1] : '0;
  assign sys_data  = sys_valid ? sram_rdata[int'(r_pipe_row[READ_LAT-1])*DATA_W +: DATA_W]
                               : '0;

endmodule

// File: tb/tb_weight_bank_ctrl.sv
// -----------------------------------------------------------------------------
// tb_weight_bank_ctrl
//
// Directed bench for weight_bank_ctrl. Two instances: dut1 (READ_LAT=1) for
// the main scenarios and dut3 (READ_LAT=3) for the latency sweep, each with
// its own behavioural SRAM. sel3 routes host stimulus and the observed outputs
// to one instance at a time. Expected values are hand-derived cycle numbers
// relative to the edge that samples load_weights (edge 0).
// -----------------------------------------------------------------------------
module tb_weight_bank_ctrl;

  localparam int NB = 8;
  localparam int DW = 64;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst;
  logic sel3;
  logic wr_valid;
  logic [DW-1:0] wr_data;
  logic load_weights;

  always #5 clk = ~clk;

  // ---------------- dut1: READ_LAT = 1 ----------------
  logic          d1_wr_ready, d1_busy, d1_start, d1_sys_valid, d1_done, d1_err, d1_we;
  logic [DW-1:0] d1_sys_data, d1_wdata;
  logic [2:0]    d1_sys_row;
  logic [NB-1:0] d1_cs;
  logic [AW-1:0] d1_addr;
  logic [NB*DW-1:0] d1_rdata;

  weight_bank_ctrl #(.NUM_BANKS(NB), .DATA_W(DW), .ADDR_W(AW), .READ_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid && !sel3), .wr_data(wr_data), .wr_ready(d1_wr_ready),
    .load_weights(load_weights && !sel3), .busy(d1_busy), .start_weights(d1_start),
    .sys_valid(d1_sys_valid), .sys_data(d1_sys_data), .sys_row(d1_sys_row),
    .weights_done(d1_done), .err(d1_err),
    .sram_cs(d1_cs), .sram_we(d1_we), .sram_addr(d1_addr), .sram_wdata(d1_wdata),
    .sram_rdata(d1_rdata)
  );

  logic [DW-1:0]    mem1 [NB][2];
  logic [NB*DW-1:0] rq1;
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (d1_cs[b]) begin
        if (d1_we) mem1[b][d1_addr[0]] <= d1_wdata;
        else       rq1[b*DW +: DW] <= mem1[b][d1_addr[0]];
      end
    end
  end
  assign d1_rdata = rq1;

  // ---------------- dut3: READ_LAT = 3 ----------------
  logic          d3_wr_ready, d3_busy, d3_start, d3_sys_valid, d3_done, d3_err, d3_we;
  logic [DW-1:0] d3_sys_data, d3_wdata;
  logic [2:0]    d3_sys_row;
  logic [NB-1:0] d3_cs;
  logic [AW-1:0] d3_addr;
  logic [NB*DW-1:0] d3_rdata;

  weight_bank_ctrl #(.NUM_BANKS(NB), .DATA_W(DW), .ADDR_W(AW), .READ_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid && sel3), .wr_data(wr_data), .wr_ready(d3_wr_ready),
    .load_weights(load_weights && sel3), .busy(d3_busy), .start_weights(d3_start),
    .sys_valid(d3_sys_valid), .sys_data(d3_sys_data), .sys_row(d3_sys_row),
    .weights_done(d3_done), .err(d3_err),
    .sram_cs(d3_cs), .sram_we(d3_we), .sram_addr(d3_addr), .sram_wdata(d3_wdata),
    .sram_rdata(d3_rdata)
  );

  logic [DW-1:0]    mem3 [NB][2];
  logic [NB*DW-1:0] rq3a, rq3b, rq3c;
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (d3_cs[b]) begin
        if (d3_we) mem3[b][d3_addr[0]] <= d3_wdata;
        else       rq3a[b*DW +: DW] <= mem3[b][d3_addr[0]];
      end
    end
    rq3b <= rq3a;
    rq3c <= rq3b;
  end
  assign d3_rdata = rq3c;

  // ---------------- observed outputs of the selected instance ----------------
  logic          ob_wr_ready, ob_busy, ob_start, ob_sys_valid, ob_done, ob_err, ob_we;
  logic [DW-1:0] ob_sys_data, ob_wdata;
  logic [2:0]    ob_sys_row;
  logic [NB-1:0] ob_cs;
  logic [AW-1:0] ob_addr;

  assign ob_wr_ready  = sel3 ? d3_wr_ready  : d1_wr_ready;
  assign ob_busy      = sel3 ? d3_busy      : d1_busy;
  assign ob_start     = sel3 ? d3_start     : d1_start;
  assign ob_sys_valid = sel3 ? d3_sys_valid : d1_sys_valid;
  assign ob_done      = sel3 ? d3_done      : d1_done;
  assign ob_err       = sel3 ? d3_err       : d1_err;
  assign ob_we        = sel3 ? d3_we        : d1_we;
  assign ob_sys_data  = sel3 ? d3_sys_data  : d1_sys_data;
  assign ob_wdata     = sel3 ? d3_wdata     : d1_wdata;
  assign ob_sys_row   = sel3 ? d3_sys_row   : d1_sys_row;
  assign ob_cs        = sel3 ? d3_cs        : d1_cs;
  assign ob_addr      = sel3 ? d3_addr      : d1_addr;

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] exp_row [16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Writes rows first..first+n-1 of the set whose data starts at exp_row[base].
  task automatic write_rows(input int base, input int slot, input int first, input int n);
    logic [7:0] one8;
    one8 = 8'd1;
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = exp_row[base + first + i];
      @(negedge clk);
      check("wr_ready", 64'(ob_wr_ready), 64'd1);
      check("wr_cs",    64'(ob_cs), 64'(one8 << (first + i)));
      check("wr_we",    64'(ob_we), 64'd1);
      check("wr_addr",  64'(ob_addr), 64'(slot));
      check("wr_wdata", ob_wdata, exp_row[base + first + i]);
      tick();
    end
    wr_valid = 1'b0;
  endtask

  // Pulses load at edge 0 and checks cycles 1..NB+lat+2 against the timing
  // derived from the read latency.
  task automatic run_stream(input int lat, input int slot, input int base, input bit busy_load);
    int  last;
    bit  v;
    int  r;
    logic [7:0] one8;
    one8 = 8'd1;
    last = NB + lat + 1;
    load_weights = 1'b1;
    @(negedge clk);
    check("ld_err", 64'(ob_err), 64'd0);
    check("ld_busy", 64'(ob_busy), 64'd0);
    tick();
    load_weights = 1'b0;
    for (int c = 1; c <= last + 1; c++) begin
      if (busy_load && c == 3) load_weights = 1'b1;
      @(negedge clk);
      v = (c >= 1 + lat) && (c <= NB + lat);
      r = c - 1 - lat;
      check("start", 64'(ob_start), 64'(c == 1));
      check("busy",  64'(ob_busy),  64'(c <= last));
      check("done",  64'(ob_done),  64'(c == last));
      check("valid", 64'(ob_sys_valid), 64'(v));
      if (v) begin
        check("row",  64'(ob_sys_row), 64'(r));
        check("data", ob_sys_data, exp_row[base + r]);
      end
      if (c <= NB) begin
        check("rd_cs",   64'(ob_cs), 64'(one8 << (c - 1)));
        check("rd_we",   64'(ob_we), 64'd0);
        check("rd_addr", 64'(ob_addr), 64'(slot));
      end
      if (busy_load && c == 3) check("busy_ld_err", 64'(ob_err), 64'd1);
      tick();
      load_weights = 1'b0;
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 8; i++)
      exp_row[i] = (i % 2 == 0) ? 64'h1111_2222_3333_4444 : 64'h2222_3333_4444_5555;
    for (int i = 8; i < 16; i++)
      exp_row[i] = 64'hA0 + 64'(i - 8);

    rst = 1'b1; sel3 = 1'b0; wr_valid = 1'b0; wr_data = '0; load_weights = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_wr_ready", 64'(ob_wr_ready), 64'd1);
    check("rst_busy",     64'(ob_busy), 64'd0);
    check("rst_cs",       64'(ob_cs), 64'd0);
    check("rst_valid",    64'(ob_sys_valid), 64'd0);
    check("rst_err",      64'(ob_err), 64'd0);
    tick();

    // Load with nothing full: err, stays idle
    load_weights = 1'b1;
    @(negedge clk);
    check("empty_ld_err", 64'(ob_err), 64'd1);
    tick();
    load_weights = 1'b0;
    @(negedge clk);
    check("empty_ld_busy", 64'(ob_busy), 64'd0);
    check("empty_ld_err_gone", 64'(ob_err), 64'd0);
    tick();

    // Basic: one set into slot 0, stream it (cycles 1..11)
    write_rows(0, 0, 0, 8);
    run_stream(1, 0, 0, 1'b0);

    // Reset mid-stream: set into slot 1, abort while row 3 is issued
    write_rows(8, 1, 0, 8);
    load_weights = 1'b1;
    tick();
    load_weights = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("pre_rst_cs",   64'(ob_cs), 64'h08);
    check("pre_rst_busy", 64'(ob_busy), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy",  64'(ob_busy), 64'd0);
    check("mid_rst_start", 64'(ob_start), 64'd0);
    check("mid_rst_valid", 64'(ob_sys_valid), 64'd0);
    check("mid_rst_data",  ob_sys_data, 64'd0);
    check("mid_rst_row",   64'(ob_sys_row), 64'd0);
    check("mid_rst_done",  64'(ob_done), 64'd0);
    check("mid_rst_err",   64'(ob_err), 64'd0);
    check("mid_rst_cs",    64'(ob_cs), 64'd0);
    check("mid_rst_we",    64'(ob_we), 64'd0);
    check("mid_rst_addr",  64'(ob_addr), 64'd0);
    check("mid_rst_wdata", ob_wdata, 64'd0);
    check("mid_rst_wr_ready", 64'(ob_wr_ready), 64'd1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      check("post_rst_done",  64'(ob_done), 64'd0);
      check("post_rst_valid", 64'(ob_sys_valid), 64'd0);
      tick();
    end
    @(negedge clk);
    check("post_rst_wr_ready", 64'(ob_wr_ready), 64'd1);
    tick();

    // Ping/pong: two sets back to back, slot 0 then slot 1
    write_rows(0, 0, 0, 8);
    write_rows(8, 1, 0, 8);
    @(negedge clk);
    check("pp_full_wr_ready", 64'(ob_wr_ready), 64'd0);
    tick();
    // Write while both slots full: dropped
    wr_valid = 1'b1;
    wr_data  = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    check("drop_err", 64'(ob_err), 64'd1);
    check("drop_cs",  64'(ob_cs), 64'd0);
    tick();
    wr_valid = 1'b0;
    run_stream(1, 0, 0, 1'b0);
    @(negedge clk);
    check("pp_wr_ready_back", 64'(ob_wr_ready), 64'd1);
    tick();
    run_stream(1, 1, 8, 1'b1);

    // Dropped row did not advance the counter: next write is row 0 of slot 0
    write_rows(0, 0, 0, 7);
    // Completion of the set in the same cycle as a load: load sees no full set
    wr_valid     = 1'b1;
    wr_data      = exp_row[7];
    load_weights = 1'b1;
    @(negedge clk);
    check("same_cyc_cs",  64'(ob_cs), 64'h80);
    check("same_cyc_err", 64'(ob_err), 64'd1);
    tick();
    wr_valid     = 1'b0;
    load_weights = 1'b0;
    @(negedge clk);
    check("same_cyc_busy", 64'(ob_busy), 64'd0);
    tick();
    run_stream(1, 0, 0, 1'b0);

    // Latency sweep on the READ_LAT=3 instance
    sel3 = 1'b1;
    @(negedge clk);
    check("l3_idle", 64'(ob_busy), 64'd0);
    tick();
    write_rows(0, 0, 0, 8);
    run_stream(3, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
